// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between the icache and the dcache.
//
// One word is served per grant. The dcache has priority, but a streak counter
// forces an icache grant after STARVE_MAX consecutive dcache words that
// completed while the icache was waiting.
//
// Ports:
//   CLK, nRST                clock, asynchronous active-low reset
//   iREN, iaddr              icache read request and word address
//   iload, iwait             icache read data and stall
//   dREN, dWEN               dcache read / write request (write wins)
//   daddr, dstore            dcache word address and write data
//   dload, dwait             dcache read data and stall
//   ramREN, ramWEN           RAM read / write enables
//   ramaddr, ramstore        RAM address and write data
//   ramload, ramstate        RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   err_flag                 sticky error seen while a requester was granted
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned RAM_W      = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    // icache side
    input  logic             iREN,
    input  logic [RAM_W-1:0] iaddr,
    output logic [RAM_W-1:0] iload,
    output logic             iwait,
    // dcache side
    input  logic             dREN,
    input  logic             dWEN,
    input  logic [RAM_W-1:0] daddr,
    input  logic [RAM_W-1:0] dstore,
    output logic [RAM_W-1:0] dload,
    output logic             dwait,
    // RAM port
    output logic             ramREN,
    output logic             ramWEN,
    output logic [RAM_W-1:0] ramaddr,
    output logic [RAM_W-1:0] ramstore,
    input  logic [RAM_W-1:0] ramload,
    input  logic [1:0]       ramstate,
    // status
    output logic             err_flag
);

    localparam logic [1:0] RamFree   = 2'd0;
    localparam logic [1:0] RamBusy   = 2'd1;
    localparam logic [1:0] RamAccess = 2'd2;
    localparam logic [1:0] RamError  = 2'd3;

    localparam logic [3:0] StreakMax = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDserv = 2'd1,
        StIserv = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] streak;
    logic       err_q;

    logic d_req;
    logic i_force;
    logic ram_access;
    logic ram_error;
    logic granted;

    assign d_req      = dREN | dWEN;
    // icache has been passed over often enough; it wins the next arbitration
    assign i_force    = iREN && (streak == StreakMax);
    assign ram_access = (ramstate == RamAccess);
    assign ram_error  = (ramstate == RamError);
    assign granted    = (state != StIdle);

    // State, streak counter and sticky error bit.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= StIdle;
            streak <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (!iREN) begin
                        streak <= '0;
                    end
                    if (d_req && !i_force) begin
                        state <= StDserv;
                    end else if (iREN) begin
                        state <= StIserv;
                    end
                end

                StDserv: begin
                    if (ram_error) begin
                        err_q <= 1'b1;
                    end
                    if (ram_access) begin
                        state <= StIdle;
                        // only words that kept the icache waiting count
                        if (iREN && (streak < StreakMax)) begin
                            streak <= streak + 4'd1;
                        end
                    end else if (!d_req) begin
                        // requester withdrew: abandon the word, no completion
                        state <= StIdle;
                    end
                end

                StIserv: begin
                    if (ram_error) begin
                        err_q <= 1'b1;
                    end
                    if (ram_access) begin
                        state  <= StIdle;
                        streak <= '0;
                    end else if (!iREN) begin
                        state <= StIdle;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    // RAM port and requester-side outputs follow the granted side directly so
    // a zero-wait RAM completes a word in the grant cycle itself.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;

        case (state)
            StDserv: begin
                ramaddr  = daddr;
                ramstore = dstore;
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                dwait    = ~ram_access;
                if (ram_access) begin
                    dload = ramload;
                end
            end

            StIserv: begin
                ramaddr = iaddr;
                ramREN  = iREN;
                iwait   = ~ram_access;
                if (ram_access) begin
                    iload = ramload;
                end
            end

            default: begin
            end
        endcase
    end

    // Visible in the ERROR cycle itself, then held by err_q until reset.
    assign err_flag = err_q | (granted && ram_error);

    // FREE and BUSY need no handling beyond holding the grant.
    logic unused_status;
    assign unused_status = (ramstate == RamFree) | (ramstate == RamBusy);

endmodule
